// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard stall/flush control, debug halt/step FSM and event counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_id_ex_mem_read,
  input  logic [4:0]       i_id_ex_rt,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  input  logic             i_if_id_uses_rt,
  input  logic             i_ex_mispredicted,
  input  logic             i_ex_is_halt,
  input  logic             i_dbg_halt_req,
  input  logic             i_dbg_step,
  input  logic             i_dbg_resume,
  input  logic             i_clr_counts,
  output logic             o_pipe_enable,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             load_use;
  logic             stall_applied;
  logic             flush_applied;

  assign load_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                    ((i_id_ex_rt == i_if_id_rs) ||
                     (i_if_id_uses_rt && (i_id_ex_rt == i_if_id_rt)));

  always_comb begin
    state_d       = state_q;
    o_pipe_enable = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_halted      = 1'b0;
    stall_applied = 1'b0;
    flush_applied = 1'b0;

    case (state_q)
      ST_HALTED: begin
        o_halted = 1'b1;
        if (i_dbg_resume) begin
          state_d = ST_RUN;
        end else if (i_dbg_step) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        o_pipe_enable = 1'b1;
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        // A mispredict squashes the younger instructions, so any load-use stall is moot.
        if (i_ex_mispredicted) begin
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          flush_applied = 1'b1;
        end else if (load_use) begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          o_id_ex_flush = 1'b1;
          stall_applied = 1'b1;
        end
        if (state_q == ST_STEP) begin
          state_d = ST_HALTED;
        end else if (i_ex_is_halt || i_dbg_halt_req) begin
          state_d = ST_HALTED;
        end
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (i_clr_counts) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_applied && !(&stall_count_q)) begin
        stall_count_d = stall_count_q + C_CNT_ONE;
      end
      if (flush_applied && !(&flush_count_q)) begin
        flush_count_d = flush_count_q + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign o_stall_count = stall_count_q;
  assign o_flush_count = flush_count_q;

endmodule

`default_nettype wire
